// File: rtl/char_compositor.sv
// Composites NUM_CHARS fighters (body + facing-aware attack boxes) over a background,
// with per-character hit-flash timers and a 2-stage pixel pipeline. Optional RENDER_SHADOW_EN.
module char_compositor #(
    parameter int unsigned NUM_CHARS    = 2,
    parameter int unsigned CHAR_W       = 128,
    parameter int unsigned CHAR_H       = 240,
    parameter logic [7:0]  BG_COLOR     = 8'hFF,
    parameter int unsigned FLASH_FRAMES = 16
) (
    input  logic                        vga_clk,
    input  logic                        rst,
    input  logic [9:0]                  x,
    input  logic [9:0]                  y,
    input  logic                        frame_start,
    input  logic [10*NUM_CHARS-1:0]     char_x_pos,
    input  logic [10*NUM_CHARS-1:0]     char_y_pos,
    input  logic [4*NUM_CHARS-1:0]      char_state,
    input  logic [NUM_CHARS-1:0]        char_facing,
    input  logic [NUM_CHARS-1:0]        hit_pulse,
    output logic [7:0]                  pixel_color,
    output logic [NUM_CHARS-1:0]        hit_flash_active
);

    localparam int unsigned CW = 10;
    localparam int unsigned SW = 4;
    localparam int unsigned TW = 8;
    localparam int unsigned PW = 8;
    // One bit beyond the 11-bit signed range so cx+3W/2 near the right edge cannot wrap.
    localparam int unsigned GW = 12;

    localparam logic signed [GW-1:0] W_M1      = GW'(CHAR_W - 1);
    localparam logic signed [GW-1:0] HALF_W    = GW'(CHAR_W / 2);
    localparam logic signed [GW-1:0] H_M1      = GW'(CHAR_H - 1);
    localparam logic signed [GW-1:0] LOW_TOP   = GW'(CHAR_H - 60);
    localparam logic signed [GW-1:0] HIGH_TOP  = GW'(CHAR_H - 140);
    localparam logic signed [GW-1:0] HIGH_BOT  = GW'(CHAR_H - 81);
    localparam logic [PW-1:0]        ATK_COLOR   = 8'hE0;
    localparam logic [PW-1:0]        FLASH_COLOR = 8'hF0;

    logic [CW*NUM_CHARS-1:0] src_x;
    logic [CW*NUM_CHARS-1:0] src_y;
    logic [SW*NUM_CHARS-1:0] src_state;
    logic [NUM_CHARS-1:0]    src_facing;

`ifdef RENDER_SHADOW_EN
    // Character geometry is latched once per frame so mid-frame updates cannot tear.
    logic [CW*NUM_CHARS-1:0] sh_x;
    logic [CW*NUM_CHARS-1:0] sh_y;
    logic [SW*NUM_CHARS-1:0] sh_state;
    logic [NUM_CHARS-1:0]    sh_facing;

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            sh_x      <= '0;
            sh_y      <= '0;
            sh_state  <= '0;
            sh_facing <= '0;
        end else if (frame_start) begin
            sh_x      <= char_x_pos;
            sh_y      <= char_y_pos;
            sh_state  <= char_state;
            sh_facing <= char_facing;
        end
    end

    assign src_x      = sh_x;
    assign src_y      = sh_y;
    assign src_state  = sh_state;
    assign src_facing = sh_facing;
`else
    assign src_x      = char_x_pos;
    assign src_y      = char_y_pos;
    assign src_state  = char_state;
    assign src_facing = char_facing;
`endif

    function automatic logic signed [GW-1:0] to_s(input logic [CW-1:0] v);
        return $signed({{(GW-CW){1'b0}}, v});
    endfunction

    function automatic logic in_range(input logic signed [GW-1:0] v,
                                      input logic signed [GW-1:0] lo,
                                      input logic signed [GW-1:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

    function automatic logic [PW-1:0] body_color(input logic [SW-1:0] st);
        case (st)
            4'd0, 4'd1, 4'd2, 4'd4, 4'd7: return 8'h00;
            4'd3:                         return 8'h1C;
            4'd5, 4'd8:                   return 8'hFC;
            4'd6:                         return 8'h1F;
            default:                      return 8'h01;
        endcase
    endfunction

    // Hit-flash timers: a hit reloads, frame_start counts down to zero.
    logic [TW-1:0] timer     [NUM_CHARS];
    logic [TW-1:0] timer_nxt [NUM_CHARS];

    always_comb begin
        for (int i = 0; i < NUM_CHARS; i++) begin
            timer_nxt[i] = timer[i];
            if (hit_pulse[i]) begin
                timer_nxt[i] = TW'(FLASH_FRAMES);
            end else if (frame_start && (timer[i] != '0)) begin
                timer_nxt[i] = timer[i] - TW'(1);
            end
        end
    end

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CHARS; i++) begin
                timer[i] <= '0;
            end
            hit_flash_active <= '0;
        end else begin
            for (int i = 0; i < NUM_CHARS; i++) begin
                timer[i]            <= timer_nxt[i];
                hit_flash_active[i] <= (timer_nxt[i] != '0);
            end
        end
    end

    // Stage 1 combinational: per-character geometry tests and resolved body colour.
    logic signed [GW-1:0] gx;
    logic signed [GW-1:0] gy;
    logic signed [GW-1:0] cx_c [NUM_CHARS];
    logic signed [GW-1:0] cy_c [NUM_CHARS];
    logic signed [GW-1:0] ax_c [NUM_CHARS];
    logic [SW-1:0]        st_c [NUM_CHARS];
    logic [NUM_CHARS-1:0] body_hit_c;
    logic [NUM_CHARS-1:0] atk_hit_c;
    logic [PW-1:0]        body_col_c [NUM_CHARS];

    assign gx = to_s(x);
    assign gy = to_s(y);

    always_comb begin
        body_hit_c = '0;
        atk_hit_c  = '0;
        for (int i = 0; i < NUM_CHARS; i++) begin
            cx_c[i] = to_s(src_x[i*CW +: CW]);
            cy_c[i] = to_s(src_y[i*CW +: CW]);
            st_c[i] = src_state[i*SW +: SW];
            ax_c[i] = src_facing[i] ? (cx_c[i] - HALF_W) : (cx_c[i] + HALF_W);

            body_hit_c[i] = in_range(gx, cx_c[i], cx_c[i] + W_M1) &&
                            in_range(gy, cy_c[i], cy_c[i] + H_M1);

            if (in_range(gx, ax_c[i], ax_c[i] + W_M1)) begin
                if (((st_c[i] == 4'd4) || (st_c[i] == 4'd7)) &&
                    in_range(gy, cy_c[i] + LOW_TOP, cy_c[i] + H_M1)) begin
                    atk_hit_c[i] = 1'b1;
                end
                if ((st_c[i] == 4'd7) &&
                    in_range(gy, cy_c[i] + HIGH_TOP, cy_c[i] + HIGH_BOT)) begin
                    atk_hit_c[i] = 1'b1;
                end
            end

            if ((timer[i] != '0) && timer[i][1]) begin
                body_col_c[i] = FLASH_COLOR;
            end else begin
                body_col_c[i] = body_color(st_c[i]);
            end
        end
    end

    logic                 s1_valid;
    logic [NUM_CHARS-1:0] s1_body;
    logic [NUM_CHARS-1:0] s1_atk;
    logic [PW-1:0]        s1_col [NUM_CHARS];

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_body  <= '0;
            s1_atk   <= '0;
            for (int i = 0; i < NUM_CHARS; i++) begin
                s1_col[i] <= '0;
            end
        end else begin
            s1_valid <= 1'b1;
            s1_body  <= body_hit_c;
            s1_atk   <= atk_hit_c;
            for (int i = 0; i < NUM_CHARS; i++) begin
                s1_col[i] <= body_col_c[i];
            end
        end
    end

    // Stage 2: scan high index to low so the lowest index overwrites last; boxes beat bodies.
    logic [PW-1:0] pix_c;

    always_comb begin
        pix_c = BG_COLOR;
        for (int i = int'(NUM_CHARS) - 1; i >= 0; i--) begin
            if (s1_body[i]) begin
                pix_c = s1_col[i];
            end
        end
        for (int i = int'(NUM_CHARS) - 1; i >= 0; i--) begin
            if (s1_atk[i]) begin
                pix_c = ATK_COLOR;
            end
        end
        if (!s1_valid) begin
            pix_c = '0;
        end
    end

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            pixel_color <= '0;
        end else begin
            pixel_color <= pix_c;
        end
    end

endmodule

// File: tb/tb_char_compositor.sv
// Directed bench for char_compositor: geometry table, pipelined sweep, flash timer,
// reset and (RENDER_SHADOW_EN-aware) position-update latency.
module tb_char_compositor;

    logic        vga_clk = 1'b0;
    logic        rst;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        frame_start;
    logic [19:0] char_x_pos;
    logic [19:0] char_y_pos;
    logic [7:0]  char_state;
    logic [1:0]  char_facing;
    logic [1:0]  hit_pulse;
    logic [7:0]  pixel_color;
    logic [1:0]  hit_flash_active;

    int checks   = 0;
    int failures = 0;

    char_compositor dut (
        .vga_clk          (vga_clk),
        .rst              (rst),
        .x                (x),
        .y                (y),
        .frame_start      (frame_start),
        .char_x_pos       (char_x_pos),
        .char_y_pos       (char_y_pos),
        .char_state       (char_state),
        .char_facing      (char_facing),
        .hit_pulse        (hit_pulse),
        .pixel_color      (pixel_color),
        .hit_flash_active (hit_flash_active)
    );

    always #5 vga_clk = ~vga_clk;

    typedef struct {
        logic [9:0] cx0, cy0;
        logic [3:0] s0;
        logic       f0;
        logic [9:0] cx1, cy1;
        logic [3:0] s1;
        logic       f1;
        logic [9:0] px, py;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int cx0, input int cy0, input int s0, input int f0,
                                input int cx1, input int cy1, input int s1, input int f1,
                                input int px, input int py, input int exp);
        vec_t v;
        v.cx0 = 10'(cx0); v.cy0 = 10'(cy0); v.s0 = 4'(s0); v.f0 = 1'(f0);
        v.cx1 = 10'(cx1); v.cy1 = 10'(cy1); v.s1 = 4'(s1); v.f1 = 1'(f1);
        v.px  = 10'(px);  v.py  = 10'(py);  v.exp = 8'(exp);
        return v;
    endfunction

    task automatic tick;
        @(posedge vga_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic frame_pulse;
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
    endtask

    // Drives character inputs; with shadows enabled a frame_start makes them visible.
    task automatic set_chars(input vec_t v);
        char_x_pos  = {v.cx1, v.cx0};
        char_y_pos  = {v.cy1, v.cy0};
        char_state  = {v.s1, v.s0};
        char_facing = {v.f1, v.f0};
`ifdef RENDER_SHADOW_EN
        frame_pulse;
`else
        tick;
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   exp_t;
        int   active_frames;
        vec_t v;

        rst = 1'b1; x = '0; y = '0; frame_start = 1'b0;
        char_x_pos = '0; char_y_pos = '0; char_state = '0; char_facing = '0; hit_pulse = '0;
        tick; tick; tick;
        chk("reset_pixel", pixel_color, 8'h00);
        chk("reset_flash", {6'b0, hit_flash_active}, 8'h00);
        rst = 1'b0;
        tick;

        // c0 fields, c1 fields, x, y, expected colour
        vecs.push_back(mk(100,200,0,0, 700,0,0,0,  99,300, 8'hFF));
        vecs.push_back(mk(100,200,0,0, 700,0,0,0, 100,300, 8'h00));
        vecs.push_back(mk(100,200,0,0, 700,0,0,0, 227,300, 8'h00));
        vecs.push_back(mk(100,200,0,0, 700,0,0,0, 228,300, 8'hFF));
        vecs.push_back(mk(100,200,0,0, 700,0,0,0, 150,199, 8'hFF));
        vecs.push_back(mk(100,200,0,0, 700,0,0,0, 150,439, 8'h00));
        vecs.push_back(mk(100,200,0,0, 700,0,0,0, 150,440, 8'hFF));
        vecs.push_back(mk(100,200,4,0, 700,0,0,0, 164,400, 8'hE0));
        vecs.push_back(mk(100,200,4,0, 700,0,0,0, 291,400, 8'hE0));
        vecs.push_back(mk(100,200,4,0, 700,0,0,0, 292,400, 8'hFF));
        vecs.push_back(mk(100,200,4,0, 700,0,0,0, 163,400, 8'h00));
        vecs.push_back(mk(100,200,4,0, 700,0,0,0, 200,379, 8'h00));
        vecs.push_back(mk(100,200,4,0, 700,0,0,0, 250,379, 8'hFF));
        vecs.push_back(mk(100,200,4,0, 700,0,0,0, 260,300, 8'hFF));
        vecs.push_back(mk(100,200,4,1, 700,0,0,0,  36,400, 8'hE0));
        vecs.push_back(mk(100,200,4,1, 700,0,0,0,  35,400, 8'hFF));
        vecs.push_back(mk(100,200,4,1, 700,0,0,0, 163,400, 8'hE0));
        vecs.push_back(mk(100,200,4,1, 700,0,0,0, 164,400, 8'h00));
        vecs.push_back(mk(100,200,3,0, 700,0,0,0, 150,300, 8'h1C));
        vecs.push_back(mk(100,200,5,0, 700,0,0,0, 150,300, 8'hFC));
        vecs.push_back(mk(100,200,6,0, 700,0,0,0, 150,300, 8'h1F));
        vecs.push_back(mk(100,200,8,0, 700,0,0,0, 150,300, 8'hFC));
        vecs.push_back(mk(100,200,9,0, 700,0,0,0, 150,300, 8'h01));
        vecs.push_back(mk(100,200,15,0,700,0,0,0, 150,300, 8'h01));
        vecs.push_back(mk(100,200,1,0, 700,0,0,0, 150,300, 8'h00));
        vecs.push_back(mk(100,200,3,0, 700,0,0,0, 200,400, 8'h1C));
        vecs.push_back(mk(100,200,7,0, 250,300,3,0, 260,300, 8'hE0));
        vecs.push_back(mk(100,200,7,0, 250,300,3,0, 260,359, 8'hE0));
        vecs.push_back(mk(100,200,7,0, 250,300,3,0, 260,360, 8'h1C));
        vecs.push_back(mk(100,200,7,0, 250,300,3,0, 260,379, 8'h1C));
        vecs.push_back(mk(100,200,7,0, 250,300,3,0, 260,380, 8'hE0));
        vecs.push_back(mk(100,200,7,0, 250,300,3,0, 260,299, 8'hFF));
        vecs.push_back(mk(100,200,3,0, 150,250,6,0, 200,300, 8'h1C));
        vecs.push_back(mk(100,200,3,0, 150,250,6,0, 250,300, 8'h1F));
        vecs.push_back(mk(100,200,0,0, 150,200,4,0, 220,400, 8'hE0));
        vecs.push_back(mk( 20,  0,4,1, 700,0,0,0,   0,200, 8'hE0));
        vecs.push_back(mk(1000,900,4,0,700,0,0,0,1023,1000, 8'h00));
        vecs.push_back(mk(1000,900,4,0,700,0,0,0, 999,1000, 8'hFF));

        foreach (vecs[k]) begin
            set_chars(vecs[k]);
            x = vecs[k].px;
            y = vecs[k].py;
            tick;
            tick;
            chk($sformatf("vec%0d_x%0d_y%0d", k, vecs[k].px, vecs[k].py), pixel_color, vecs[k].exp);
        end

        // Back-to-back sweep: one pixel per cycle, each result exactly 2 cycles later.
        set_chars(mk(100,200,0,0, 700,0,0,0, 0,0, 0));
        y = 10'd300;
        for (int k = 0; k < 131; k++) begin
            if (k < 130) x = 10'(99 + k);
            tick;
            if (k >= 1) begin
                chk($sformatf("sweep_x%0d", 99 + k - 1), pixel_color,
                    ((99 + k - 1) >= 100 && (99 + k - 1) <= 227) ? 8'h00 : 8'hFF);
            end
        end

        // Flash timer on char1 body at (150,300).
        set_chars(mk(700,0,0,0, 100,200,0,0, 0,0, 0));
        x = 10'd150; y = 10'd300;
        hit_pulse = 2'b10;
        tick;
        hit_pulse = 2'b00;
        chk("flash_load_active", {6'b0, hit_flash_active}, 8'h02);
        tick; tick;
        chk("flash_t16_pixel", pixel_color, 8'h00);
        active_frames = 1;
        for (int f = 1; f <= 16; f++) begin
            frame_pulse;
            exp_t = 16 - f;
            if (hit_flash_active[1]) active_frames++;
            chk($sformatf("flash_active_f%0d", f), {6'b0, hit_flash_active},
                (exp_t != 0) ? 8'h02 : 8'h00);
            tick; tick;
            chk($sformatf("flash_pixel_f%0d", f), pixel_color,
                ((exp_t != 0) && ((exp_t & 2) != 0)) ? 8'hF0 : 8'h00);
        end
        chk("flash_frame_count", 8'(active_frames), 8'd16);
        frame_pulse;
        chk("flash_saturate", {6'b0, hit_flash_active}, 8'h00);

        // Reload during an active flash, coinciding with frame_start.
        hit_pulse = 2'b10;
        tick;
        hit_pulse = 2'b00;
        for (int f = 0; f < 3; f++) frame_pulse;
        hit_pulse = 2'b10;
        frame_pulse;
        hit_pulse = 2'b00;
        for (int f = 0; f < 14; f++) frame_pulse;
        tick; tick;
        chk("reload_t2_pixel", pixel_color, 8'hF0);
        chk("reload_t2_active", {6'b0, hit_flash_active}, 8'h02);
        frame_pulse;
        tick; tick;
        chk("reload_t1_pixel", pixel_color, 8'h00);
        chk("reload_t1_active", {6'b0, hit_flash_active}, 8'h02);
        frame_pulse;
        chk("reload_t0_active", {6'b0, hit_flash_active}, 8'h00);

        // Reset in the middle of a flash.
        hit_pulse = 2'b10;
        tick;
        hit_pulse = 2'b00;
        frame_pulse;
        frame_pulse;
        tick; tick;
        chk("pre_rst_flash_pixel", pixel_color, 8'hF0);
        x = 10'd50;
        rst = 1'b1;
        tick;
        chk("rst_pixel_a", pixel_color, 8'h00);
        chk("rst_flash_a", {6'b0, hit_flash_active}, 8'h00);
        tick; tick;
        chk("rst_pixel_b", pixel_color, 8'h00);
        rst = 1'b0;
        tick;
        chk("post_rst_cycle1", pixel_color, 8'h00);
        tick;
        chk("post_rst_cycle2", pixel_color, 8'hFF);
        v = mk(700,0,0,0, 100,200,0,0, 0,0, 0);
        set_chars(v);
        x = 10'd150;
        tick; tick;
        chk("post_rst_no_flash", pixel_color, 8'h00);
        chk("post_rst_active", {6'b0, hit_flash_active}, 8'h00);

        // Mid-frame position change of char0.
        set_chars(mk(100,200,0,0, 700,0,0,0, 0,0, 0));
        x = 10'd100; y = 10'd300;
        tick; tick;
        chk("move_before", pixel_color, 8'h00);
        char_x_pos[9:0] = 10'd300;
        tick;
        chk("move_plus1", pixel_color, 8'h00);
        tick;
`ifdef RENDER_SHADOW_EN
        chk("move_plus2_held", pixel_color, 8'h00);
        tick; tick; tick;
        chk("move_plus5_held", pixel_color, 8'h00);
        frame_pulse;
        tick; tick;
        chk("move_after_frame", pixel_color, 8'hFF);
`else
        chk("move_plus2", pixel_color, 8'hFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
